audio_frame_buffer: RTL and testbench
=====================================

// Module: audio_frame_buffer
// PURPOSE
//   Consumer end of the preprocessed audio stream: accepts signed 16-bit samples,
//   stores them in a circular buffer and replays overlapping frames (FRAME_LEN long,
//   advancing HOP_LEN per frame) to the feature-extraction stage over valid/ready.
//   Sits between preprocessing and the MFCC/feature engine.
// PARAMETERS
//   FRAME_LEN  256  samples per output frame
//   HOP_LEN    128  frame advance in samples; 1 <= HOP_LEN <= FRAME_LEN
//   BUF_DEPTH  512  circular buffer depth; power of 2, >= FRAME_LEN + HOP_LEN
//   ADDR_W     9    log2(BUF_DEPTH)
// PORTS
//   clk            in   1   system clock; all logic on rising edge
//   rst            in   1   synchronous, active-high reset
//   sample_in      in   16  signed audio sample
//   sample_valid   in   1   sample_in valid this cycle; no backpressure upstream
//   frame_data     out  16  signed frame sample
//   frame_valid    out  1   frame_data valid
//   frame_ready    in   1   downstream accepts when frame_valid && frame_ready
//   frame_first    out  1   qualifies first sample of a frame
//   frame_last     out  1   qualifies last sample of a frame
//   overflow       out  1   sticky: a sample was dropped
//   frame_energy   out  40  sum of squares of last completed frame (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0; wr_ptr=rd_base=0; count=0; state FILL; buffer contents don't-care.
//   count = wr_ptr - rd_base (mod 2^(ADDR_W+1)), unread samples from current frame base.
//   Write: sample_valid && count<BUF_DEPTH -> store at wr_ptr, wr_ptr++ (wraps).
//   Write when count==BUF_DEPTH -> sample dropped, overflow<=1 until rst.
//   FSM: FILL -> READ when count>=FRAME_LEN; READ -> FILL after frame_last handshake.
//   READ: rd_idx 0..FRAME_LEN-1 reads buffer[rd_base+rd_idx]; registered read, so
//     frame_valid rises 2 cycles after FILL->READ decision; one sample per accepted beat.
//   Hold rule: frame_valid && !frame_ready -> frame_data/first/last held stable.
//   No bubbles while frame_ready held high: one beat per cycle for the whole frame.
//   frame_first with rd_idx==0 beat; frame_last with rd_idx==FRAME_LEN-1 beat.
//   Frame complete (last beat accepted): rd_base += HOP_LEN; frame_valid 0 next cycle;
//     next frame may start immediately if count (post-update) >= FRAME_LEN.
//   Simultaneous write and frame completion same cycle: both applied; count uses both.
//   Writes continue during READ; samples in the replayed window are never overwritten
//     because count<=BUF_DEPTH guards wr_ptr against rd_base.
//   Wrap: all pointer arithmetic mod BUF_DEPTH for addressing; no special case at seam.
//   rst mid-frame: frame abandoned, outputs 0 next cycle, buffer logically emptied.
// CONFIGURATION
//   FRAME_ENERGY_EN defined: 40-bit accumulator adds frame_data*frame_data (signed
//     16x16 -> 32, zero-extended) on each accepted beat; cleared on frame_first beat
//     (loaded with that square); on frame_last beat result latches into frame_energy,
//     held until next frame_last or rst.
//   FRAME_ENERGY_EN undefined: no multiplier/accumulator; frame_energy tied to 0.
// TESTING (bench params FRAME_LEN=8, HOP_LEN=4, BUF_DEPTH=16)
//   Reset: rst=1 for 2 cycles -> all outputs 0, no frame_valid until 8 samples written.
//   Samples 1..8 then frame_ready=1 -> frame 1..8 with first on 1, last on 8, no gaps.
//   Continue 9..12 -> second frame 5..12 (overlap 4); third after 13..16 is 9..16.
//   frame_ready toggled 1/0 each cycle -> data held during stalls, order intact, 8 beats.
//   frame_ready=0, 17 samples pushed -> 17th dropped, overflow=1 and stays 1; first frame 1..8.
//   FRAME_ENERGY_EN, frame of eight -32768 -> frame_energy = 8*2^30 = 8589934592;
//     without macro frame_energy stays 0.

Source files
------------

// File: rtl/audio_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_buffer
// Description : Circular sample buffer that replays overlapping frames
//               (FRAME_LEN long, HOP_LEN advance) over valid/ready.
//               Optional macro FRAME_ENERGY_EN adds a per-frame sum of squares.
// Revision    : 1.0  initial release
// ============================================================================
module audio_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int HOP_LEN   = 128,
  parameter int BUF_DEPTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic signed [15:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               frame_first,
  output logic               frame_last,
  output logic               overflow,
  output logic [39:0]        frame_energy
);

  localparam logic [ADDR_W:0] FRAME_LEN_P = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] HOP_LEN_P   = (ADDR_W+1)'(HOP_LEN);
  localparam logic [ADDR_W:0] DEPTH_P     = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] ONE_P       = (ADDR_W+1)'(1);

  typedef enum logic {FILL = 1'b0, READ = 1'b1} state_t;

  logic signed [15:0] mem [BUF_DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_base;
  logic [ADDR_W:0]    rd_idx;
  logic [ADDR_W:0]    count;
  logic [ADDR_W-1:0]  rd_addr;
  state_t             state;
  logic               wr_en;
  logic               accept;
  logic               load;
  logic               done;

  // Pointers carry one extra bit so a full buffer is distinguishable from empty.
  always_comb begin
    count   = wr_ptr - rd_base;
    wr_en   = sample_valid && (count < DEPTH_P);
    accept  = frame_valid && frame_ready;
    done    = accept && frame_last;
    rd_addr = rd_base[ADDR_W-1:0] + rd_idx[ADDR_W-1:0];
    load    = (state == READ) && (rd_idx < FRAME_LEN_P) && (!frame_valid || frame_ready);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      rd_base     <= '0;
      rd_idx      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      if (sample_valid && !wr_en) begin
        overflow <= 1'b1;
      end
      case (state)
        FILL: begin
          if (count >= FRAME_LEN_P) begin
            state  <= READ;
            rd_idx <= '0;
          end
        end
        READ: begin
          if (done) begin
            state       <= FILL;
            rd_base     <= rd_base + HOP_LEN_P;
            frame_valid <= 1'b0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
          end else if (load) begin
            frame_data  <= mem[rd_addr];
            frame_valid <= 1'b1;
            frame_first <= (rd_idx == '0);
            frame_last  <= (rd_idx == FRAME_LEN_P - ONE_P);
            rd_idx      <= rd_idx + ONE_P;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef FRAME_ENERGY_EN
  logic signed [31:0] sq;
  logic [39:0]        acc;
  logic [39:0]        acc_next;

  // First beat of a frame restarts the sum with its own square.
  always_comb begin
    sq       = frame_data * frame_data;
    acc_next = frame_first ? {8'd0, sq} : acc + {8'd0, sq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      frame_energy <= '0;
    end else if (accept) begin
      acc <= acc_next;
      if (frame_last) begin
        frame_energy <= acc_next;
      end
    end
  end
`else
  assign frame_energy = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_frame_buffer
// Description : Directed self-checking bench, FRAME_LEN=8 HOP_LEN=4 BUF_DEPTH=16.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_frame_buffer;

  localparam int FRAME_LEN = 8;
  localparam int HOP_LEN   = 4;
  localparam int BUF_DEPTH = 16;
  localparam int ADDR_W    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] frame_data;
  logic               frame_valid;
  logic               frame_ready = 1'b0;
  logic               frame_first;
  logic               frame_last;
  logic               overflow;
  logic [39:0]        frame_energy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_frame_buffer #(
    .FRAME_LEN (FRAME_LEN),
    .HOP_LEN   (HOP_LEN),
    .BUF_DEPTH (BUF_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_first  (frame_first),
    .frame_last   (frame_last),
    .overflow     (overflow),
    .frame_energy (frame_energy)
  );

  typedef struct {
    int n_push;
    int push_base;
    bit toggle;
    int exp_start;
  } rec_t;

  rec_t tbl [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      sample_in    = 16'(base + i);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // Collects one frame; in toggle mode ready alternates and stalled beats are re-checked.
  task automatic collect(input int ev [8], input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit started = 1'b0;
    while (idx < 8 && cyc < 100) begin
      frame_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (!toggle && started) check("no_gap", 64'(frame_valid), 64'd1);
      if (frame_valid) begin
        started = 1'b1;
        check("beat", {frame_data, frame_first, frame_last},
              {16'(ev[idx]), (idx == 0), (idx == 7)});
        if (frame_ready) idx++;
      end
      tick();
      cyc++;
    end
    frame_ready = 1'b0;
    check("frame_timeout", 64'(idx), 64'd8);
    check("valid_drop", 64'(frame_valid), 64'd0);
  endtask

  task automatic run_frame(input int start, input bit toggle);
    int ev [8];
    for (int i = 0; i < 8; i++) ev[i] = start + i;
    collect(ev, toggle);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev [8];
    int waited;
    tbl[0] = '{n_push: 1, push_base: 8,  toggle: 1'b0, exp_start: 1};
    tbl[1] = '{n_push: 4, push_base: 9,  toggle: 1'b0, exp_start: 5};
    tbl[2] = '{n_push: 4, push_base: 13, toggle: 1'b0, exp_start: 9};
    tbl[3] = '{n_push: 4, push_base: 17, toggle: 1'b1, exp_start: 13};

    do_reset();
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_data", 64'(frame_data), 64'd0);
    check("rst_first_last", {frame_first, frame_last}, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_energy", 64'(frame_energy), 64'd0);

    push(1, 7);
    repeat (4) tick();
    check("no_frame_at_7", 64'(frame_valid), 64'd0);

    for (int r = 0; r < 4; r++) begin
      push(tbl[r].push_base, tbl[r].n_push);
      run_frame(tbl[r].exp_start, tbl[r].toggle);
    end

    // Reset in the middle of a frame abandons it and empties the buffer.
    push(21, 4);
    waited = 0;
    while (!frame_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("midrst_valid_seen", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(frame_valid), 64'd0);
    check("midrst_data", 64'(frame_data), 64'd0);
    check("midrst_first_last", {frame_first, frame_last}, 64'd0);
    rst = 1'b0;
    frame_ready = 1'b0;
    push(200, 7);
    repeat (4) tick();
    check("midrst_empty", 64'(frame_valid), 64'd0);
    push(207, 1);
    run_frame(200, 1'b0);

    // Overflow: 17th sample into a full buffer is dropped.
    do_reset();
    push(1, 16);
    check("ovf_before", 64'(overflow), 64'd0);
    push(17, 1);
    check("ovf_set", 64'(overflow), 64'd1);
    repeat (3) tick();
    check("ovf_sticky", 64'(overflow), 64'd1);
    run_frame(1, 1'b0);
    run_frame(5, 1'b0);
    run_frame(9, 1'b0);
    push(100, 4);
    ev = '{13, 14, 15, 16, 100, 101, 102, 103};
    collect(ev, 1'b0);
    check("ovf_still", 64'(overflow), 64'd1);

    // Energy: eight full-scale negative samples.
    do_reset();
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    push(32768, 1);
    ev = '{32768, 32768, 32768, 32768, 32768, 32768, 32768, 32768};
    collect(ev, 1'b0);
    tick();
`ifdef FRAME_ENERGY_EN
    check("energy", 64'(frame_energy), 64'd8589934592);
`else
    check("energy", 64'(frame_energy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
